// File: rtl/vmem_arbiter.sv
// vmem_arbiter: round-robin arbiter/sequencer in front of the 16-lane vector
// data memory. Requester A is the vector load/store unit, requester B the
// DMA/preload engine. One access is in flight at a time. Each access runs as
// ACCESS -> DONE, and the next arbitration happens in the DONE cycle.
//
// Ports
//   clk, reset                : posedge clock, async active-low reset
//   req_x/we_x/addr_x/wdata_x : request from requester x (x = a, b)
//   gnt_x                     : 1-cycle pulse, request latched (ACCESS cycle)
//   done_x/err_x/rdata_x      : 1-cycle completion pulse, range error, read data
//   mem_addr/mem_we/mem_wdata : registered drive to the memory (writes on negedge)
//   mem_rdata                 : combinational read data from the memory

// Per-lane read-data capture for both requesters.
module vmem_arbiter_lane #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_a,
    input  logic         ld_b,
    input  logic         keep,     // 1: capture din, 0: capture zero
    input  logic [W-1:0] din,
    output logic [W-1:0] rd_a,
    output logic [W-1:0] rd_b
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_a <= '0;
            rd_b <= '0;
        end else begin
            if (ld_a) rd_a <= keep ? din : '0;
            if (ld_b) rd_b <= keep ? din : '0;
        end
    end
endmodule

module vmem_arbiter #(
    parameter int LANES     = 16,
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 9,
    parameter int MEM_WORDS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              done_a,
    output logic              err_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              done_b,
    output logic              err_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int WORD_W = DATA_W / LANES;
    // Highest base address whose full window still fits in memory.
    localparam logic [ADDR_W:0] LAST_BASE = (ADDR_W+1)'(MEM_WORDS - LANES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nxt;
    logic              last_b;    // 1: B won the last arbitration
    logic              owner_b;   // 1: access in flight belongs to B
    logic              lat_we;
    logic              rng;       // latched in-range flag of the access in flight
    logic              arb_en, pick_a, pick_b, grant;
    logic              sel_we, sel_rng;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_access;

    // Arbitration is open in IDLE and DONE; a tie goes to the requester
    // that did not win last time.
    assign arb_en    = (state != ACCESS);
    assign pick_a    = arb_en & req_a & (~req_b | last_b);
    assign pick_b    = arb_en & req_b & (~req_a | ~last_b);
    assign grant     = pick_a | pick_b;
    assign in_access = (state == ACCESS);

    assign sel_we    = pick_b ? we_b    : we_a;
    assign sel_addr  = pick_b ? addr_b  : addr_a;
    assign sel_wdata = pick_b ? wdata_b : wdata_a;
    assign sel_rng   = ({1'b0, sel_addr} <= LAST_BASE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = grant ? ACCESS : IDLE;
            ACCESS:     state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // mem_we is a plain flop cleared by the async reset, so a reset during
    // ACCESS drops the write enable before the memory's negedge write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_b    <= 1'b1;
            owner_b   <= 1'b0;
            lat_we    <= 1'b0;
            rng       <= 1'b0;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            err_a     <= 1'b0;
            err_b     <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            gnt_a  <= pick_a;
            gnt_b  <= pick_b;
            done_a <= in_access & ~owner_b;
            done_b <= in_access &  owner_b;
            err_a  <= in_access & ~owner_b & ~rng;
            err_b  <= in_access &  owner_b & ~rng;
            mem_we <= 1'b0;
            if (grant) begin
                last_b    <= pick_b;
                owner_b   <= pick_b;
                lat_we    <= sel_we;
                rng       <= sel_rng;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_we    <= sel_we & sel_rng;
            end
        end
    end

    // Read data is captured at the close of ACCESS; writes and out-of-range
    // accesses load zero.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vmem_arbiter_lane #(.W(WORD_W)) u_lane (
            .clk  (clk),
            .reset(reset),
            .ld_a (in_access & ~owner_b),
            .ld_b (in_access &  owner_b),
            .keep (rng & ~lat_we),
            .din  (mem_rdata[i*WORD_W +: WORD_W]),
            .rd_a (rdata_a[i*WORD_W +: WORD_W]),
            .rd_b (rdata_b[i*WORD_W +: WORD_W])
        );
    end
endmodule

// File: tb/tb_vmem_arbiter.sv
module tb_vmem_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic         req_a, we_a, req_b, we_b;
    logic [8:0]   addr_a, addr_b;
    logic [511:0] wdata_a, wdata_b;
    logic         gnt_a, done_a, err_a, gnt_b, done_b, err_b;
    logic [511:0] rdata_a, rdata_b;
    logic [8:0]   mem_addr;
    logic         mem_we;
    logic [511:0] mem_wdata, mem_rdata;

    vmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .done_a(done_a), .err_a(err_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .done_b(done_b), .err_b(err_b), .rdata_b(rdata_b),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: word i initialised to 0xA0000000+i, writes on negedge.
    logic [31:0] tbmem [0:511];
    bit          init_done = 1'b0;
    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 512; i++) tbmem[i] <= 32'hA000_0000 + 32'(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            for (int i = 0; i < 16; i++)
                tbmem[(int'(mem_addr) + i) % 512] <= mem_wdata[i*32 +: 32];
        end
    end
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 16; i++)
            mem_rdata[i*32 +: 32] = tbmem[(int'(mem_addr) + i) % 512];
    end

    function automatic logic [511:0] pat(input logic [31:0] base);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = base + 32'(i);
        return v;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           is_b;
        bit           err;
        logic [511:0] rd;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit is_b, input bit err, input logic [511:0] rd);
        exp_t e;
        e.is_b = is_b; e.err = err; e.rd = rd;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every done pulse is checked against the queue head.
    always @(negedge clk) begin
        if (reset && (done_a || done_b)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", {done_a, done_b}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_done_who", {done_a, done_b}, e.is_b ? 2'b01 : 2'b10);
                chk("sb_err", e.is_b ? err_b : err_a, e.err);
                chk("sb_rdata", e.is_b ? rdata_b : rdata_a, e.rd);
            end
        end
    end

    // One access: drive request, expect grant after one sample, check the
    // memory drive in ACCESS, then return at the start of the DONE cycle.
    task automatic access(input bit is_b, input bit we, input logic [8:0] addr,
                          input logic [511:0] wd, input bit exp_err,
                          input logic [511:0] exp_rd);
        int  n;
        bit  got;
        push(is_b, exp_err, exp_rd);
        if (is_b) begin req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; end
        else      begin req_a = 1; we_a = we; addr_a = addr; wdata_a = wd; end
        n = 0; got = 0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            got = is_b ? gnt_b : gnt_a;
        end
        chk("gnt_latency", 32'(n), 32'd1);
        chk("access_mem_we", mem_we, we & !exp_err);
        chk("access_mem_addr", mem_addr, addr);
        if (is_b) req_b = 0; else req_a = 0;
        @(posedge clk); #1;
        chk("done_cycle_done", is_b ? done_b : done_a, 1'b1);
        chk("done_cycle_mem_we", mem_we, 1'b0);
    endtask

    initial begin
        reset = 0;
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
        #1;
        chk("rst_gnt_done_err", {gnt_a, gnt_b, done_a, done_b, err_a, err_b}, 6'b0);
        chk("rst_mem_ctl", {mem_we, mem_addr}, 10'b0);
        chk("rst_mem_wdata", mem_wdata, 512'b0);
        chk("rst_rdata", rdata_a | rdata_b, 512'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1;

        // Simultaneous requests after reset: A,B,A,B, grants two cycles apart.
        push(0, 0, pat(32'hA000_0000 + 300));
        push(1, 0, pat(32'hA000_0000 + 400));
        push(0, 0, pat(32'hA000_0000 + 300));
        push(1, 0, pat(32'hA000_0000 + 400));
        req_a = 1; we_a = 0; addr_a = 9'd300;
        req_b = 1; we_b = 0; addr_b = 9'd400;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("tie_gnt_k%0d", k), {gnt_a, gnt_b},
                {(k == 1 || k == 5), (k == 3 || k == 7)});
            if (k == 7) begin req_a = 0; req_b = 0; end
        end

        // Single write then read at 32.
        access(0, 1, 9'd32, pat(32'h1000), 0, 512'b0);
        access(0, 0, 9'd32, 512'b0, 0, pat(32'h1000));

        // Out of range write, then read of the last legal window.
        access(1, 1, 9'd497, pat(32'h5555_0000), 1, 512'b0);
        access(1, 0, 9'd496, 512'b0, 0, pat(32'hA000_0000 + 496));
        access(1, 0, 9'd497, 512'b0, 1, 512'b0);

        // Boundary round-trip at 496.
        access(0, 1, 9'd496, pat(32'h2000), 0, 512'b0);
        access(0, 0, 9'd496, 512'b0, 0, pat(32'h2000));

        // Back-to-back A, then B joins and wins the next arbitration.
        @(posedge clk); #1;
        push(0, 0, pat(32'hA000_0000 + 100));
        push(0, 0, pat(32'hA000_0000 + 100));
        push(1, 0, pat(32'hA000_0000 + 200));
        push(0, 0, pat(32'hA000_0000 + 100));
        req_a = 1; we_a = 0; addr_a = 9'd100;
        we_b = 0; addr_b = 9'd200;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_gnt_k%0d", k), {gnt_a, gnt_b},
                {(k == 1 || k == 3 || k == 7), (k == 5)});
            if (k == 3) req_b = 1;
            if (k == 5) req_b = 0;
            if (k == 7) req_a = 0;
        end

        // Reset during a B write's ACCESS, before the negedge.
        @(posedge clk); #1;
        req_b = 1; we_b = 1; addr_b = 9'd64; wdata_b = pat(32'hDEAD_0000);
        @(posedge clk); #1;
        chk("rstmid_gnt_b", gnt_b, 1'b1);
        chk("rstmid_mem_we_before", mem_we, 1'b1);
        req_b = 0;
        #1 reset = 0;
        #1;
        chk("rstmid_mem_we_after", mem_we, 1'b0);
        chk("rstmid_ctl", {gnt_a, gnt_b, done_a, done_b, err_a, err_b, mem_addr}, 15'b0);
        chk("rstmid_rdata", rdata_a | rdata_b | mem_wdata, 512'b0);
        @(negedge clk); #2 reset = 1;
        @(posedge clk); #1;
        begin
            logic [511:0] cur;
            for (int i = 0; i < 16; i++) cur[i*32 +: 32] = tbmem[64 + i];
            chk("rstmid_mem_unchanged", cur, pat(32'hA000_0000 + 64));
        end
        push(0, 0, pat(32'hA000_0000 + 64));
        req_a = 1; we_a = 0; addr_a = 9'd64;
        req_b = 1; we_b = 0; addr_b = 9'd64;
        @(posedge clk); #1;
        chk("rstmid_tie_gnt", {gnt_a, gnt_b}, 2'b10);
        req_a = 0; req_b = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
